// File: rtl/battleship_board_pkg.sv
// Shared definitions for the Battleship game engine and its VGA renderer:
// cell/phase encodings, board defaults and the button bundle.
package battleship_board_pkg;

  localparam int unsigned GRID_DEF  = 10;
  localparam int unsigned SHIPS_DEF = 5;
  localparam int unsigned COORD_W   = 4;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned CELL_W    = 2;
  localparam int unsigned PHASE_W   = 3;

  // Coordinate value the renderer drives when the beam is outside the grid.
  localparam logic [COORD_W-1:0] OUT_OF_BOUNDS = 4'hF;

  typedef enum logic [CELL_W-1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_MISS  = 2'd2,
    CELL_HIT   = 2'd3
  } cell_e;

  typedef enum logic [PHASE_W-1:0] {
    P1_PLACE  = 3'd0,
    P2_PLACE  = 3'd1,
    P1_TURN   = 3'd2,
    P2_TURN   = 3'd3,
    GAME_OVER = 3'd4
  } phase_e;

  typedef struct packed {
    logic fire;
    logic up;
    logic down;
    logic left;
    logic right;
  } btn_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] max);
    return (cnt >= max) ? max : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/battleship_board_cursor.sv
// Board cursor: wrap-around row/col counter with fire > up > down > left > right priority.
module board_cursor
  import battleship_board_pkg::*;
#(
  parameter int unsigned GRID = GRID_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  btn_t               btn_i,
  input  logic               hold_i,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o
);

  localparam logic [COORD_W-1:0] LAST = COORD_W'(GRID - 1);

  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;

  // A fire pulse claims the cycle, so it suppresses any movement.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (!hold_i && !btn_i.fire) begin
      if (btn_i.up) begin
        row_d = (row_q == '0) ? LAST : row_q - COORD_W'(1);
      end else if (btn_i.down) begin
        row_d = (row_q == LAST) ? '0 : row_q + COORD_W'(1);
      end else if (btn_i.left) begin
        col_d = (col_q == '0) ? LAST : col_q - COORD_W'(1);
      end else if (btn_i.right) begin
        col_d = (col_q == LAST) ? '0 : col_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/battleship_board.sv
// Battleship game-state engine: two boards, cursor, turn FSM and a registered read port.
// Optional BATTLESHIP_FOG_OF_WAR_EN hides unhit ships on the read port during turns.
module battleship_board
  import battleship_board_pkg::*;
#(
  parameter int unsigned GRID  = GRID_DEF,
  parameter int unsigned SHIPS = SHIPS_DEF
) (
  input  logic               clk_vga,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_fire,
  input  logic               rd_board,
  input  logic [COORD_W-1:0] rd_row,
  input  logic [COORD_W-1:0] rd_col,
  output logic [CELL_W-1:0]  rd_cell,
  output logic [COORD_W-1:0] cursor_row,
  output logic [COORD_W-1:0] cursor_col,
  output logic [PHASE_W-1:0] phase,
  output logic               winner
);

  localparam logic [CNT_W-1:0] SHIPS_C = CNT_W'(SHIPS);

  cell_e              cell_q [2][GRID][GRID];
  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   placed_q, placed_d;
  logic [CNT_W-1:0]   p1_hits_q, p1_hits_d;
  logic [CNT_W-1:0]   p2_hits_q, p2_hits_d;
  logic               winner_q, winner_d;
  logic [CELL_W-1:0]  rd_cell_q, rd_cell_d;

  btn_t               btn_c;
  logic               wr_en_c;
  logic               wr_board_c;
  cell_e              wr_val_c;
  cell_e              cur_cell_c;
  logic               shooter_c;
  logic [CNT_W-1:0]   placed_inc_c;
  logic [CNT_W-1:0]   hits_inc_c;
  logic               rd_in_range_c;
  logic               fog_active_c;
  cell_e              rd_val_c;

  assign btn_c.fire  = btn_fire;
  assign btn_c.up    = btn_up;
  assign btn_c.down  = btn_down;
  assign btn_c.left  = btn_left;
  assign btn_c.right = btn_right;

  board_cursor #(.GRID(GRID)) u_cursor (
    .clk    (clk_vga),
    .rst_n  (rst),
    .btn_i  (btn_c),
    .hold_i (phase_q == GAME_OVER),
    .row_o  (cursor_row),
    .col_o  (cursor_col)
  );

  // Placing writes the own board; shooting writes the opponent's board.
  assign wr_board_c   = (phase_q == P2_PLACE) || (phase_q == P1_TURN);
  assign shooter_c    = (phase_q == P2_TURN);
  assign cur_cell_c   = cell_q[wr_board_c][cursor_row][cursor_col];
  assign placed_inc_c = sat_inc(placed_q, SHIPS_C);
  assign hits_inc_c   = sat_inc(shooter_c ? p2_hits_q : p1_hits_q, SHIPS_C);

  always_comb begin
    phase_d   = phase_q;
    placed_d  = placed_q;
    p1_hits_d = p1_hits_q;
    p2_hits_d = p2_hits_q;
    winner_d  = winner_q;
    wr_en_c   = 1'b0;
    wr_val_c  = CELL_EMPTY;
    case (phase_q)
      P1_PLACE, P2_PLACE: begin
        if (btn_fire && cur_cell_c == CELL_EMPTY) begin
          wr_en_c  = 1'b1;
          wr_val_c = CELL_SHIP;
          if (placed_inc_c == SHIPS_C) begin
            placed_d = '0;
            phase_d  = (phase_q == P1_PLACE) ? P2_PLACE : P1_TURN;
          end else begin
            placed_d = placed_inc_c;
          end
        end
      end
      P1_TURN, P2_TURN: begin
        if (btn_fire && cur_cell_c == CELL_SHIP) begin
          wr_en_c  = 1'b1;
          wr_val_c = CELL_HIT;
          if (shooter_c) p2_hits_d = hits_inc_c;
          else           p1_hits_d = hits_inc_c;
          if (hits_inc_c == SHIPS_C) begin
            phase_d  = GAME_OVER;
            winner_d = shooter_c;
          end else begin
            phase_d  = shooter_c ? P1_TURN : P2_TURN;
          end
        end else if (btn_fire && cur_cell_c == CELL_EMPTY) begin
          wr_en_c  = 1'b1;
          wr_val_c = CELL_MISS;
          phase_d  = shooter_c ? P1_TURN : P2_TURN;
        end
      end
      default: ;
    endcase
  end

`ifdef BATTLESHIP_FOG_OF_WAR_EN
  assign fog_active_c = (phase_q == P1_TURN) || (phase_q == P2_TURN);
`else
  assign fog_active_c = 1'b0;
`endif

  // Read port samples pre-write storage, so a same-cycle write shows next cycle.
  assign rd_in_range_c = (rd_row < COORD_W'(GRID)) && (rd_col < COORD_W'(GRID));

  always_comb begin
    rd_val_c = CELL_EMPTY;
    if (rd_in_range_c) rd_val_c = cell_q[rd_board][rd_row][rd_col];
    if (fog_active_c && rd_val_c == CELL_SHIP) rd_val_c = CELL_EMPTY;
    rd_cell_d = rd_val_c;
  end

  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      cell_q    <= '{default: CELL_EMPTY};
      phase_q   <= P1_PLACE;
      placed_q  <= '0;
      p1_hits_q <= '0;
      p2_hits_q <= '0;
      winner_q  <= 1'b0;
      rd_cell_q <= CELL_EMPTY;
    end else begin
      if (wr_en_c) cell_q[wr_board_c][cursor_row][cursor_col] <= wr_val_c;
      phase_q   <= phase_d;
      placed_q  <= placed_d;
      p1_hits_q <= p1_hits_d;
      p2_hits_q <= p2_hits_d;
      winner_q  <= winner_d;
      rd_cell_q <= rd_cell_d;
    end
  end

  assign rd_cell = rd_cell_q;
  assign phase   = phase_q;
  assign winner  = winner_q;

endmodule

// File: tb/tb_battleship_board.sv
// Bench for battleship_board: board-level game model checked every cycle plus directed literal checks.
module tb_battleship_board;

  localparam int G = 10;
  localparam int S = 5;
`ifdef BATTLESHIP_FOG_OF_WAR_EN
  localparam int FOG = 1;
`else
  localparam int FOG = 0;
`endif

  logic       clk_vga = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_fire;
  logic       rd_board;
  logic [3:0] rd_row, rd_col;
  logic [1:0] rd_cell;
  logic [3:0] cursor_row, cursor_col;
  logic [2:0] phase;
  logic       winner;

  int n_checks = 0;
  int n_err    = 0;

  battleship_board dut (
    .clk_vga    (clk_vga),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_fire   (btn_fire),
    .rd_board   (rd_board),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_cell    (rd_cell),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .phase      (phase),
    .winner     (winner)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Game model: cells 0 empty, 1 ship, 2 miss, 3 hit; phases 0..4 as in the game rules.
  int m_cell [2][G][G];
  int m_row, m_col, m_phase, m_placed, m_winner, m_rd;
  int m_hits [2];

  task automatic model_fire();
    int b, sh;
    if (m_phase <= 1) begin
      b = m_phase;
      if (m_cell[b][m_row][m_col] == 0) begin
        m_cell[b][m_row][m_col] = 1;
        m_placed++;
        if (m_placed == S) begin
          m_placed = 0;
          m_phase++;
        end
      end
    end else begin
      sh = m_phase - 2;
      b  = 1 - sh;
      if (m_cell[b][m_row][m_col] == 1) begin
        m_cell[b][m_row][m_col] = 3;
        m_hits[sh]++;
        if (m_hits[sh] == S) begin
          m_phase  = 4;
          m_winner = sh;
        end else m_phase = 5 - m_phase;
      end else if (m_cell[b][m_row][m_col] == 0) begin
        m_cell[b][m_row][m_col] = 2;
        m_phase = 5 - m_phase;
      end
    end
  endtask

  always @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      foreach (m_cell[b, r, c]) m_cell[b][r][c] = 0;
      m_row = 0; m_col = 0; m_phase = 0; m_placed = 0; m_winner = 0; m_rd = 0;
      m_hits[0] = 0; m_hits[1] = 0;
    end else begin
      if (int'(rd_row) >= G || int'(rd_col) >= G) m_rd = 0;
      else begin
        m_rd = m_cell[rd_board][rd_row][rd_col];
        if (FOG == 1 && (m_phase == 2 || m_phase == 3) && m_rd == 1) m_rd = 0;
      end
      if (m_phase != 4) begin
        if (btn_fire)       model_fire();
        else if (btn_up)    m_row = (m_row + G - 1) % G;
        else if (btn_down)  m_row = (m_row + 1) % G;
        else if (btn_left)  m_col = (m_col + G - 1) % G;
        else if (btn_right) m_col = (m_col + 1) % G;
      end
    end
  end

  always @(negedge clk_vga) begin
    if (rst) begin
      chk("phase", int'(phase), m_phase);
      chk("cursor_row", int'(cursor_row), m_row);
      chk("cursor_col", int'(cursor_col), m_col);
      chk("rd_cell", int'(rd_cell), m_rd);
      if (m_phase == 4) chk("winner", int'(winner), m_winner);
    end
  end

  int p_r [2][S] = '{'{2, 0, 1, 5, 9}, '{4, 0, 2, 6, 8}};
  int p_c [2][S] = '{'{3, 0, 1, 5, 9}, '{4, 1, 2, 6, 8}};

  task automatic step();
    @(posedge clk_vga);
    #2;
  endtask

  task automatic press(input logic f, u, d, l, r);
    btn_fire = f; btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    step();
    btn_fire = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  task automatic goto_cell(input int r, input int c);
    for (int k = 0; k < G && m_row != r; k++) press(0, 0, 1, 0, 0);
    for (int k = 0; k < G && m_col != c; k++) press(0, 0, 0, 0, 1);
  endtask

  task automatic fire_at(input int r, input int c);
    goto_cell(r, c);
    press(1, 0, 0, 0, 0);
  endtask

  task automatic rd_lit(input string nm, input logic b, input int r, input int c, input int exp);
    rd_board = b; rd_row = 4'(r); rd_col = 4'(c);
    step();
    chk(nm, int'(rd_cell), exp);
  endtask

  task automatic place_all(input int p);
    for (int i = 0; i < S; i++) begin
      fire_at(p_r[p][i], p_c[p][i]);
      chk("place_phase", int'(phase), (i < S - 1) ? p : p + 1);
    end
  endtask

  initial begin
    rst = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0;
    rd_board = 0; rd_row = 0; rd_col = 0;
    step(); step();
    rst = 1;
    step();
    chk("reset_phase", int'(phase), 0);
    chk("reset_row", int'(cursor_row), 0);
    chk("reset_col", int'(cursor_col), 0);
    chk("reset_winner", int'(winner), 0);
    chk("reset_rd", int'(rd_cell), 0);

    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    chk("wrap_row_9", int'(cursor_row), 9);
    chk("wrap_col_9", int'(cursor_col), 9);
    press(0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 1);
    chk("wrap_row_0", int'(cursor_row), 0);
    chk("wrap_col_0", int'(cursor_col), 0);

    fire_at(2, 3);
    rd_lit("p1_ship_2_3", 1'b0, 2, 3, 1);
    place_all(0);
    chk("p1_done_phase", int'(phase), 1);
    place_all(1);
    chk("p2_done_phase", int'(phase), 2);
    rd_lit("fog_unhit_ship", 1'b1, 0, 1, (FOG == 1) ? 0 : 1);

    fire_at(4, 4);
    chk("p1_hit_phase", int'(phase), 3);
    rd_lit("p2_cell_hit", 1'b1, 4, 4, 3);
    fire_at(4, 4);
    chk("p2_miss_phase", int'(phase), 2);
    rd_lit("p1_cell_miss", 1'b0, 4, 4, 2);
    fire_at(4, 4);
    chk("refire_phase", int'(phase), 2);

    goto_cell(0, 1);
    press(1, 1, 0, 0, 0);
    chk("prio_phase", int'(phase), 3);
    chk("prio_row", int'(cursor_row), 0);
    chk("prio_col", int'(cursor_col), 1);
    fire_at(3, 3);
    fire_at(2, 2);
    fire_at(3, 4);
    fire_at(6, 6);
    fire_at(3, 5);
    fire_at(8, 8);
    chk("win_phase", int'(phase), 4);
    chk("win_winner", int'(winner), 0);

    press(1, 1, 1, 1, 1);
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    chk("over_phase", int'(phase), 4);
    chk("over_row", int'(cursor_row), 8);
    chk("over_col", int'(cursor_col), 8);
    chk("over_winner", int'(winner), 0);

    rd_lit("oob_row", 1'b1, 10, 0, 0);
    rd_lit("oob_col", 1'b1, 0, 15, 0);
    rd_lit("over_hit", 1'b1, 0, 1, 3);
    rd_lit("over_ship", 1'b0, 2, 3, 1);
    rd_lit("latency_4_4", 1'b1, 4, 4, 3);

    rst = 0;
    step();
    rst = 1;
    step();
    place_all(0);
    place_all(1);
    fire_at(3, 3);
    chk("p2_turn_reached", int'(phase), 3);
    rst = 0;
    #1;
    chk("async_rst_phase", int'(phase), 0);
    chk("async_rst_row", int'(cursor_row), 0);
    chk("async_rst_col", int'(cursor_col), 0);
    step();
    rst = 1;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < G; r++)
        for (int c = 0; c < G; c++)
          rd_lit("sweep_empty", 1'(b), r, c, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
